// File: rtl/layer2_dense_engine_if.sv
// Result stream from the layer-2 dense engine into the layer-3 input buffer.
interface layer2_dense_engine_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 7;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/layer2_dense_engine.sv
// Layer-2 fully connected engine: one MAC per cycle, ReLU + Q8.8 saturation per neuron,
// results streamed out over a valid/ready handshake.
module layer2_dense_engine #(
  parameter  int unsigned IN_LEN = 64,
  parameter  int unsigned N_OUT  = 128,
  parameter  int unsigned ACC_W  = 40,
  localparam int unsigned IA_W   = $clog2(IN_LEN),
  localparam int unsigned WA_W   = $clog2(N_OUT * IN_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IA_W-1:0]       in_addr,
  input  logic [15:0]           in_data,
  output logic [WA_W-1:0]       w_addr,
  input  logic [15:0]           w_data,
  output logic [6:0]            b_addr,
  input  logic [15:0]           b_data,
  layer2_dense_engine_if.master res
);

  localparam int unsigned NI_W = $clog2(N_OUT);

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_bias = 3'd1,
    st_mac  = 3'd2,
    st_act  = 3'd3,
    st_out  = 3'd4,
    st_fin  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NI_W-1:0]    neuron_q, neuron_d;
  logic [IA_W-1:0]    i_q, i_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic [15:0]        data_q, data_d;
  logic [NI_W-1:0]    idx_q, idx_d;

  logic [31:0]        prod;
  logic               last_i, last_neuron, hs;

  // Q8.8 x Q8.8 -> Q16.16; both operands sign-extended so the low 32 bits are exact.
  assign prod        = $signed({{16{in_data[15]}}, in_data}) * $signed({{16{w_data[15]}}, w_data});
  assign last_i      = (i_q == IA_W'(IN_LEN - 1));
  assign last_neuron = (neuron_q == NI_W'(N_OUT - 1));
  assign hs          = valid_q & res.out_ready;

  // Addresses come only from registered counters, never from the handshake.
  assign in_addr = i_q;
  assign b_addr  = 7'(neuron_q);
  assign w_addr  = WA_W'(neuron_q) * WA_W'(IN_LEN) + WA_W'(i_q);

  assign busy          = busy_q;
  assign done          = done_q;
  assign res.out_valid = valid_q;
  assign res.out_data  = data_q;
  assign res.out_idx   = 7'(idx_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= st_idle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      st_idle: if (start) state_d = st_bias;
      st_bias: state_d = st_mac;
      st_mac:  if (last_i) state_d = st_act;
      st_act:  state_d = st_out;
      st_out:  if (hs) state_d = last_neuron ? st_fin : st_bias;
      st_fin:  state_d = st_idle;
      default: state_d = st_idle;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    neuron_d = neuron_q;
    i_d      = i_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    idx_d    = idx_q;
    unique case (state_q)
      st_idle: begin
        if (start) begin
          neuron_d = '0;
          busy_d   = 1'b1;
        end
      end
      st_bias: begin
        acc_d = {{(ACC_W - 24){b_data[15]}}, b_data, 8'h00};
        i_d   = '0;
      end
      st_mac: begin
        acc_d = acc_q + {{(ACC_W - 32){prod[31]}}, prod};
        i_d   = last_i ? '0 : i_q + IA_W'(1);
      end
      st_act: begin
        // Non-negative acc: anything at or above bit 23 means r exceeds 0x7FFF.
        if (acc_q[ACC_W-1])       data_d = 16'h0000;
        else if (|acc_q[ACC_W-2:23]) data_d = 16'h7FFF;
        else                      data_d = acc_q[23:8];
        idx_d   = neuron_q;
        valid_d = 1'b1;
      end
      st_out: begin
        if (hs) begin
          valid_d = 1'b0;
          if (last_neuron) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            neuron_d = neuron_q + NI_W'(1);
          end
        end
      end
      st_fin: begin
        busy_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neuron_q <= '0;
      i_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
    end else begin
      neuron_q <= neuron_d;
      i_q      <= i_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_layer2_dense_engine.sv
// Directed bench for layer2_dense_engine with stub activation, weight and bias ROMs.
module tb_layer2_dense_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done;
  logic [5:0]  in_addr;
  logic [12:0] w_addr;
  logic [6:0]  b_addr;
  logic [15:0] in_data, w_data, b_data;
  int          checks = 0;
  int          failures = 0;
  int          mode = 0;
  logic [15:0] got [128];

  always #5 clk = ~clk;

  layer2_dense_engine_if res ();

  layer2_dense_engine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .in_addr (in_addr),
    .in_data (in_data),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .res     (res)
  );

  function automatic logic [15:0] bias_f(input int n);
    case (n)
      0:       return 16'h0000;
      1:       return 16'h0017;
      3:       return 16'hFFDF;
      73:      return 16'h0044;
      83:      return 16'hFFB4;
      default: return 16'((n * 37) % 256 - 128);
    endcase
  endfunction

  function automatic logic [15:0] act_f(input int m, input int a);
    case (m)
      0:       return 16'h0000;
      1:       return 16'h0100;
      2, 3:    return 16'h7FFF;
      default: return (a == 7) ? 16'h0100 : 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] wt_f(input int m, input int a);
    case (m)
      0:       return 16'(a * 7 + 3);
      1:       return 16'h0100;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'(a);
    endcase
  endfunction

  // Reference: exact integer sum, then ReLU and Q8.8 saturation.
  function automatic logic [15:0] model(input int m, input int n);
    longint acc, r;
    acc = longint'($signed(bias_f(n))) * 256;
    for (int i = 0; i < 64; i++)
      acc += longint'($signed(act_f(m, i))) * longint'($signed(wt_f(m, n * 64 + i)));
    r = acc >>> 8;
    if (acc < 0)         return 16'h0000;
    else if (r > 32767)  return 16'h7FFF;
    else                 return 16'(r);
  endfunction

  always_comb begin
    in_data = act_f(mode, int'(in_addr));
    w_data  = wt_f(mode, int'(w_addr));
    b_data  = bias_f(int'(b_addr));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full layer pass; checks every result, inter-result spacing and the done pulse.
  task automatic run_pass(input int m, input int stall_idx, input bit poke_start);
    int  edge_n, prev_v, wcnt;
    bit  prev_stall;
    mode = m;
    res.out_ready = 1'b1;
    step();
    start  = 1'b1;
    edge_n = 0;
    step();
    edge_n = 1;
    start  = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (poke_start) begin
      repeat (28) begin step(); edge_n++; end
      start = 1'b1;
      step();
      edge_n++;
      start = 1'b0;
      chk("busy_during_poke", 32'(busy), 32'd1);
    end
    prev_v = 0;
    prev_stall = 1'b0;
    for (int n = 0; n < 128; n++) begin
      wcnt = 0;
      while (res.out_valid !== 1'b1 && wcnt < 300) begin step(); edge_n++; wcnt++; end
      chk($sformatf("m%0d_valid_seen_%0d", m, n), 32'(res.out_valid), 32'd1);
      if (res.out_valid !== 1'b1) break;
      chk($sformatf("m%0d_idx_%0d", m, n), 32'(res.out_idx), 32'(n));
      chk($sformatf("m%0d_data_%0d", m, n), 32'(res.out_data), 32'(model(m, n)));
      chk($sformatf("m%0d_spacing_%0d", m, n), 32'(edge_n - prev_v), 32'(prev_stall ? 72 : 67));
      got[n]     = res.out_data;
      prev_v     = edge_n;
      prev_stall = (n == stall_idx);
      if (n == stall_idx) begin
        res.out_ready = 1'b0;
        repeat (5) begin
          step();
          edge_n++;
          chk("stall_valid", 32'(res.out_valid), 32'd1);
          chk("stall_idx", 32'(res.out_idx), 32'(n));
          chk("stall_data", 32'(res.out_data), 32'(got[n]));
          chk("stall_busy", 32'(busy), 32'd1);
        end
        res.out_ready = 1'b1;
      end
      step();
      edge_n++;
      chk($sformatf("m%0d_valid_drop_%0d", m, n), 32'(res.out_valid), 32'd0);
      if (n == 127) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    step();
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_after_pass", 32'(busy), 32'd0);
  endtask

  initial begin
    int wcnt;
    rst_n = 1'b0;
    start = 1'b0;
    res.out_ready = 1'b0;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(res.out_valid), 32'd0);
    chk("rst_data", 32'(res.out_data), 32'd0);
    chk("rst_idx", 32'(res.out_idx), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Zero activations: outputs are ReLU(bias); start re-asserted mid-pass is ignored.
    run_pass(0, -1, 1'b1);
    chk("zero_idx1", 32'(got[1]), 32'h0017);
    chk("zero_idx3", 32'(got[3]), 32'h0000);
    chk("zero_idx73", 32'(got[73]), 32'h0044);

    // Unit activations and weights, with backpressure on idx10.
    run_pass(1, 10, 1'b0);
    chk("ones_idx0", 32'(got[0]), 32'h4000);
    chk("ones_idx1", 32'(got[1]), 32'h4017);
    chk("ones_idx83", 32'(got[83]), 32'h3FB4);

    run_pass(2, -1, 1'b0);
    chk("sat_idx0", 32'(got[0]), 32'h7FFF);
    chk("sat_idx127", 32'(got[127]), 32'h7FFF);

    run_pass(3, -1, 1'b0);
    chk("relu_idx0", 32'(got[0]), 32'h0000);
    chk("relu_idx127", 32'(got[127]), 32'h0000);

    // Reset during the MAC phase of idx20.
    mode = 4;
    res.out_ready = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wcnt = 0;
    while (!(res.out_valid === 1'b1 && res.out_idx === 7'd19) && wcnt < 3000) begin step(); wcnt++; end
    chk("reach_idx19", 32'(res.out_idx), 32'd19);
    repeat (21) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(res.out_valid), 32'd0);
    chk("midrst_data", 32'(res.out_data), 32'd0);
    chk("midrst_idx", 32'(res.out_idx), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (3) step();
    chk("midrst_idle_busy", 32'(busy), 32'd0);
    chk("midrst_idle_valid", 32'(res.out_valid), 32'd0);

    // Fresh pass with address-dependent data: result = bias + neuron*64 + 7.
    run_pass(4, -1, 1'b0);
    chk("addr_idx0", 32'(got[0]), 32'h0007);
    chk("addr_idx2", 32'(got[2]), 32'h0051);
    chk("addr_idx5", 32'(got[5]), 32'h0180);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
